// File: rtl/output_channel_allocator_pkg.sv
// Shared definitions for the output channel allocator: flit type encodings,
// type-field position helpers and the lock FSM state type.
// Optional packet-format checker is enabled by defining PKT_ERR_CHECK_EN.
package output_channel_allocator_pkg;

  // Two-bit flit type field, carried in the top two bits of every flit
  localparam int         FLIT_TYPE_W = 2;
  localparam logic [1:0] FLIT_HEAD   = 2'b10;
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TAIL   = 2'b01;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } alloc_state_e;

  // A flit opens a packet if it is HEAD or SINGLE
  function automatic logic flit_is_head(input logic [FLIT_TYPE_W-1:0] t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

  // A flit closes a packet if it is TAIL or SINGLE
  function automatic logic flit_is_tail(input logic [FLIT_TYPE_W-1:0] t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/output_channel_allocator_flit_out_reg.sv
// Purpose: single-entry valid/ready output register for one flit.
// Latency: 1 cycle from accepted input to out_vld_o.
// Backpressure: in_rdy_o = !out_vld_o | out_rdy_i, so a full register refills in the cycle it drains.
module flit_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_vld_i,
  input  logic [DATA_WIDTH-1:0] in_dat_i,
  output logic                  in_rdy_o,
  output logic                  out_vld_o,
  output logic [DATA_WIDTH-1:0] out_dat_o,
  input  logic                  out_rdy_i
);

  logic                  vld_q;
  logic [DATA_WIDTH-1:0] dat_q;

  assign in_rdy_o  = !vld_q || out_rdy_i;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  // Load on input handshake; otherwise drain when downstream takes the flit, hold while stalled
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (in_vld_i && in_rdy_o) begin
      vld_q <= 1'b1;
      dat_q <= in_dat_i;
    end else if (out_rdy_i) begin
      vld_q <= 1'b0;
    end
  end

endmodule

// File: rtl/output_channel_allocator.sv
// Purpose: locks one input onto this output port for a whole wormhole packet (head..tail) and forwards its flits.
// Latency: grant 1 cycle after any valid in IDLE; flit appears on out_*_o 1 cycle after its input handshake.
// Backpressure: rdy_o[owner] = !out_vld_o | out_rdy_i; one bubble between packets. Macro: PKT_ERR_CHECK_EN.
module output_channel_allocator
  import output_channel_allocator_pkg::*;
#(
  parameter int IN_N       = 5,
  parameter int DATA_WIDTH = 8,
  localparam int IDX_W     = (IN_N > 1) ? $clog2(IN_N) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [IN_N-1:0]            vld_input_i,
  input  logic [IDX_W-1:0]           arb_res_i,
  input  logic [IN_N*DATA_WIDTH-1:0] data_i,
  output logic [IN_N-1:0]            rdy_o,
  output logic                       out_vld_o,
  output logic [DATA_WIDTH-1:0]      out_data_o,
  input  logic                       out_rdy_i,
  output logic                       busy_o,
  output logic                       err_o
);

  alloc_state_e            state_q;
  logic [IDX_W-1:0]        owner_q;

  logic                    accept;
  logic                    owner_vld;
  logic [DATA_WIDTH-1:0]   owner_dat;
  logic [FLIT_TYPE_W-1:0]  owner_type;
  logic                    fwd_vld;
  logic                    in_xfer;

  // Select the owner's valid and flit from the flattened input bus
  always_comb begin
    owner_vld = 1'b0;
    owner_dat = '0;
    for (int k = 0; k < IN_N; k++) begin
      if (owner_q == IDX_W'(k)) begin
        owner_vld = vld_input_i[k];
        owner_dat = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign owner_type = owner_dat[DATA_WIDTH-1:DATA_WIDTH-FLIT_TYPE_W];
  assign busy_o     = (state_q == ST_LOCKED);
  assign fwd_vld    = busy_o && owner_vld;
  assign in_xfer    = fwd_vld && accept;

  // One-hot ready towards the owner only, and only when the output stage can take a flit
  always_comb begin
    rdy_o = '0;
    if (busy_o && accept) begin
      for (int k = 0; k < IN_N; k++) begin
        rdy_o[k] = (owner_q == IDX_W'(k));
      end
    end
  end

  // Lock FSM: latch the arbiter winner in IDLE, release after the packet-closing flit is taken
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|vld_input_i) begin
            owner_q <= arb_res_i;
            state_q <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (in_xfer && flit_is_tail(owner_type)) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  flit_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_flit_out_reg (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .in_vld_i  (fwd_vld),
    .in_dat_i  (owner_dat),
    .in_rdy_o  (accept),
    .out_vld_o (out_vld_o),
    .out_dat_o (out_data_o),
    .out_rdy_i (out_rdy_i)
  );

`ifdef PKT_ERR_CHECK_EN
  logic first_q;
  logic err_q;

  assign err_o = err_q;

  // Track whether the next accepted flit is the first of the packet and flag framing violations
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && |vld_input_i) begin
        first_q <= 1'b1;
      end else if (in_xfer) begin
        first_q <= 1'b0;
        if (first_q != flit_is_head(owner_type)) begin
          err_q <= 1'b1;
        end
      end
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_output_channel_allocator.sv
// Directed per-cycle vector bench for output_channel_allocator (IN_N=5, DATA_WIDTH=8).
// Inputs are driven on the falling edge and outputs compared 1 time unit later.
module tb_output_channel_allocator;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  vld_input_i;
  logic [2:0]  arb_res_i;
  logic [39:0] data_i;
  logic [4:0]  rdy_o;
  logic        out_vld_o;
  logic [7:0]  out_data_o;
  logic        out_rdy_i;
  logic        busy_o;
  logic        err_o;

`ifdef PKT_ERR_CHECK_EN
  localparam logic E = 1'b1;
`else
  localparam logic E = 1'b0;
`endif

  output_channel_allocator #(.IN_N(5), .DATA_WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .vld_input_i (vld_input_i),
    .arb_res_i   (arb_res_i),
    .data_i      (data_i),
    .rdy_o       (rdy_o),
    .out_vld_o   (out_vld_o),
    .out_data_o  (out_data_o),
    .out_rdy_i   (out_rdy_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst_n;
    logic [4:0]  vld;
    logic [2:0]  arb;
    logic [39:0] dat;
    logic        ordy;
    logic [4:0]  e_rdy;
    logic        e_ovld;
    logic [7:0]  e_odat;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [39:0] d(input int k, input logic [7:0] f);
    logic [39:0] r;
    r = '0;
    r[k*8 +: 8] = f;
    return r;
  endfunction

  task automatic add(input logic rst_n, input logic [4:0] vld, input logic [2:0] arb,
                     input logic [39:0] dat, input logic ordy, input logic [4:0] e_rdy,
                     input logic e_ovld, input logic [7:0] e_odat, input logic e_busy,
                     input logic e_err);
    vec_t v;
    v.rst_n = rst_n; v.vld = vld; v.arb = arb; v.dat = dat; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ovld = e_ovld; v.e_odat = e_odat; v.e_busy = e_busy; v.e_err = e_err;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic [4:0] vld, input logic [2:0] arb,
                       input logic [39:0] dat, input logic ordy);
    @(negedge clk_i);
    rst_ni = rst_n; vld_input_i = vld; arb_res_i = arb; data_i = dat; out_rdy_i = ordy;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; vld_input_i = 5'b11111; arb_res_i = 3'd0; data_i = '0; out_rdy_i = 1'b1;

    // rst vld arb dat ordy | rdy ovld odat busy err
    // reset with all inputs valid
    add(0, 5'h1F, 0, '0,                     1, 5'h00, 0, 8'h00, 0, 0);  // 0
    // single packet on input 2
    add(1, 5'h04, 2, d(2, 8'h81),            1, 5'h00, 0, 8'h00, 0, 0);  // 1 idle, lock
    add(1, 5'h04, 2, d(2, 8'h81),            1, 5'h04, 0, 8'h00, 1, 0);  // 2 head taken
    add(1, 5'h04, 2, d(2, 8'h02),            1, 5'h04, 1, 8'h81, 1, 0);  // 3 body
    add(1, 5'h04, 2, d(2, 8'h43),            1, 5'h04, 1, 8'h02, 1, 0);  // 4 tail
    add(1, 5'h00, 0, '0,                     1, 5'h00, 1, 8'h43, 0, 0);  // 5 back in idle
    add(1, 5'h00, 0, '0,                     1, 5'h00, 0, 8'h43, 0, 0);  // 6 drained
    // contention: inputs 1 and 4, arbiter picks 4
    add(1, 5'h12, 4, d(4, 8'h84) | d(1, 8'h91), 1, 5'h00, 0, 8'h43, 0, 0); // 7
    add(1, 5'h12, 4, d(4, 8'h84) | d(1, 8'h91), 1, 5'h10, 0, 8'h43, 1, 0); // 8
    add(1, 5'h12, 4, d(4, 8'h05) | d(1, 8'h91), 1, 5'h10, 1, 8'h84, 1, 0); // 9
    add(1, 5'h12, 4, d(4, 8'h46) | d(1, 8'h91), 1, 5'h10, 1, 8'h05, 1, 0); // 10
    add(1, 5'h02, 1, d(1, 8'h91),            1, 5'h00, 1, 8'h46, 0, 0);  // 11 bubble
    add(1, 5'h02, 1, d(1, 8'h91),            1, 5'h02, 0, 8'h46, 1, 0);  // 12
    // backpressure for 4 cycles mid-packet
    add(1, 5'h02, 1, d(1, 8'h12),            0, 5'h00, 1, 8'h91, 1, 0);  // 13
    add(1, 5'h02, 1, d(1, 8'h12),            0, 5'h00, 1, 8'h91, 1, 0);  // 14
    add(1, 5'h02, 1, d(1, 8'h12),            0, 5'h00, 1, 8'h91, 1, 0);  // 15
    add(1, 5'h02, 1, d(1, 8'h12),            0, 5'h00, 1, 8'h91, 1, 0);  // 16
    add(1, 5'h02, 1, d(1, 8'h12),            1, 5'h02, 1, 8'h91, 1, 0);  // 17 release
    add(1, 5'h02, 1, d(1, 8'h53),            1, 5'h02, 1, 8'h12, 1, 0);  // 18 tail
    add(1, 5'h00, 0, '0,                     0, 5'h00, 1, 8'h53, 0, 0);  // 19 tail held
    // SINGLE on input 0 locks while previous tail is still held
    add(1, 5'h01, 0, d(0, 8'hE0),            0, 5'h00, 1, 8'h53, 0, 0);  // 20
    add(1, 5'h01, 0, d(0, 8'hE0),            0, 5'h00, 1, 8'h53, 1, 0);  // 21 waits
    add(1, 5'h01, 0, d(0, 8'hE0),            1, 5'h01, 1, 8'h53, 1, 0);  // 22 taken
    // HEAD on input 3, then reset before TAIL
    add(1, 5'h08, 3, d(3, 8'h8A),            1, 5'h00, 1, 8'hE0, 0, 0);  // 23 released
    add(1, 5'h08, 3, d(3, 8'h8A),            1, 5'h08, 0, 8'hE0, 1, 0);  // 24
    add(0, 5'h08, 3, d(3, 8'h0B),            1, 5'h08, 1, 8'h8A, 1, 0);  // 25 reset edge
    add(1, 5'h00, 0, '0,                     1, 5'h00, 0, 8'h00, 0, 0);  // 26
    // BODY as first flit after lock
    add(1, 5'h04, 2, d(2, 8'h0C),            1, 5'h00, 0, 8'h00, 0, 0);  // 27
    add(1, 5'h04, 2, d(2, 8'h0C),            1, 5'h04, 0, 8'h00, 1, 0);  // 28
    add(1, 5'h04, 2, d(2, 8'h4D),            1, 5'h04, 1, 8'h0C, 1, E);  // 29
    add(1, 5'h00, 0, '0,                     1, 5'h00, 1, 8'h4D, 0, E);  // 30 sticky
    add(0, 5'h00, 0, '0,                     1, 5'h00, 0, 8'h4D, 0, E);  // 31 reset edge
    add(1, 5'h00, 0, '0,                     1, 5'h00, 0, 8'h00, 0, 0);  // 32 cleared

    // two reset cycles with all inputs valid
    repeat (2) @(posedge clk_i);

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].vld, tbl[i].arb, tbl[i].dat, tbl[i].ordy);
      n_vec++;
      chk("rdy_o",      i, {3'b0, rdy_o},     {3'b0, tbl[i].e_rdy});
      chk("out_vld_o",  i, {7'b0, out_vld_o}, {7'b0, tbl[i].e_ovld});
      chk("out_data_o", i, out_data_o,        tbl[i].e_odat);
      chk("busy_o",     i, {7'b0, busy_o},    {7'b0, tbl[i].e_busy});
      chk("err_o",      i, {7'b0, err_o},     {7'b0, tbl[i].e_err});
    end

    // owner drops valid mid-packet: lock held, competing input 1 never readied
    drive(1, 5'h01, 0, d(0, 8'h81), 1);
    drive(1, 5'h01, 0, d(0, 8'h81), 1);
    n_vec++;
    chk("lock_busy", 100, {7'b0, busy_o}, 8'h01);
    chk("lock_rdy",  100, {3'b0, rdy_o},  8'h01);
    for (int c = 0; c < 4; c++) begin
      drive(1, 5'h02, 1, d(1, 8'h91), 1);
      n_vec++;
      chk("hold_busy", 101 + c, {7'b0, busy_o}, 8'h01);
      chk("hold_rdy",  101 + c, {3'b0, rdy_o},  8'h01);
      chk("hold_odat", 101 + c, out_data_o,     8'h81);
      chk("hold_ovld", 101 + c, {7'b0, out_vld_o}, (c == 0) ? 8'h01 : 8'h00);
    end
    drive(0, 5'h00, 0, '0, 1);
    drive(1, 5'h00, 0, '0, 1);
    n_vec++;
    chk("final_busy", 110, {7'b0, busy_o},    8'h00);
    chk("final_ovld", 110, {7'b0, out_vld_o}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
